// File: rtl/lq_agen_sum_pipe.sv
// LSU address-generation sum pipe: registers operands, emits byte generate/transmit
// to the carry network, and selects conditional byte sums into the ex3 effective address.
module lq_agen_sum_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex1_vld,
    input  logic [0:63] ex1_base,
    input  logic [0:63] ex1_offset,
    input  logic        ex1_mode64,
    output logic        ex1_rdy,
    input  logic        ex3_hold,
    input  logic        ex_flush,
    output logic [1:7]  g08,
    output logic [1:6]  t08,
    input  logic [1:7]  c64_b,
    output logic        ex3_vld,
    output logic [0:63] ex3_ea,
    output logic        ex3_carry
);

    logic        ex2_vld;
    logic [0:63] ex2_a;
    logic [0:63] ex2_b;
    logic        ex2_mode64;

    logic [0:7]  g_all;
    logic [0:6]  t_all;
    logic [0:63] sum0;
    logic [0:55] sum1;
    logic [0:63] ea_nxt;
    logic        carry_nxt;

    assign ex1_rdy = ~ex3_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex2_vld    <= 1'b0;
            ex2_a      <= '0;
            ex2_b      <= '0;
            ex2_mode64 <= 1'b0;
        end else begin
            if (ex_flush)
                ex2_vld <= 1'b0;
            else if (!ex3_hold)
                ex2_vld <= ex1_vld;
            if (!ex3_hold && ex1_vld) begin
                ex2_a      <= ex1_base;
                ex2_b      <= ex1_offset;
                ex2_mode64 <= ex1_mode64;
            end
        end
    end

    // Byte 7 never takes a carry-in, so its carry-in-1 sum is not built.
    always_comb begin
        g_all = '0;
        t_all = '0;
        sum0  = '0;
        sum1  = '0;
        for (int k = 0; k < 8; k++) begin
            {g_all[k], sum0[8*k +: 8]} =
                {1'b0, ex2_a[8*k +: 8]} + {1'b0, ex2_b[8*k +: 8]};
        end
        for (int k = 0; k < 7; k++) begin
            {t_all[k], sum1[8*k +: 8]} =
                {1'b0, ex2_a[8*k +: 8]} + {1'b0, ex2_b[8*k +: 8]} + 9'd1;
        end
    end

    assign g08 = g_all[1:7];
    assign t08 = t_all[1:6];

    always_comb begin
        ea_nxt = sum0;
        for (int k = 0; k < 7; k++) begin
            if (!c64_b[k+1])
                ea_nxt[8*k +: 8] = sum1[8*k +: 8];
        end
        carry_nxt = g_all[0] | (t_all[0] & ~c64_b[1]);
        if (!ex2_mode64) begin
            ea_nxt[0:31] = '0;
            carry_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex3_vld   <= 1'b0;
            ex3_ea    <= '0;
            ex3_carry <= 1'b0;
        end else begin
            if (ex_flush)
                ex3_vld <= 1'b0;
            else if (!ex3_hold)
                ex3_vld <= ex2_vld;
            if (!ex3_hold && ex2_vld) begin
                ex3_ea    <= ea_nxt;
                ex3_carry <= carry_nxt;
            end
        end
    end

endmodule
